rpg_dump: RTL and testbench

- UART memory-dump transmitter; the opposite direction of the reprogram loader path.
- On a start pulse it reads a block of 32-bit words from memory over a word read port (same 23-bit word address space as the loader write port).
- It serialises each word as 4 bytes, little-endian, UART 8N1, then sends a single XOR checksum byte.
- The host compares that checksum with the loader's xorc to confirm an upload.
- Sits beside the loader; its tx drives a GPIO pin.

---
 rtl/rpg_dump_pkg.sv | 6 +
 rtl/uart_tx_byte.sv | 47 ++++
 rtl/rpg_dump.sv | 93 +++++++++
 tb/tb_rpg_dump.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rpg_dump_pkg.sv
// rpg_dump_pkg: shared constants and FSM encoding for the UART memory-dump path.
package rpg_dump_pkg;
    localparam logic UART_IDLE = 1'b1;
    localparam int CLKS_PER_BIT_DEF = 217;
    typedef enum logic [2:0] {IDLE, RD_REQ, SEND, NEXT, SUM, FIN} state_t;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser; ready also covers the last stop-bit clock so frames chain back-to-back.
module uart_tx_byte
    import rpg_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    logic          busy;
    logic [8:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud;
    logic          bit_end;
    assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
    assign ready   = !busy || (bit_end && bit_cnt == 4'd9);
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            tx      <= UART_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
        end else if (valid && ready) begin
            busy    <= 1'b1;
            tx      <= 1'b0;
            shreg   <= {1'b1, data};
            bit_cnt <= '0;
            baud    <= '0;
        end else if (busy) begin
            if (bit_end) begin
                baud    <= '0;
                bit_cnt <= bit_cnt + 4'd1;
                tx      <= bit_cnt == 4'd9 ? UART_IDLE : shreg[0];
                shreg   <= shreg >> 1;
                busy    <= bit_cnt != 4'd9;
            end else begin
                baud <= baud + BW'(1);
            end
        end
    end
endmodule

// File: rtl/rpg_dump.sv
// rpg_dump: reads a block of words from memory and sends them little-endian over UART,
// followed by an XOR checksum byte.
module rpg_dump
    import rpg_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int ADDR_W       = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [31:0]       mem_data,
    input  logic              mem_ok,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [7:0]        xorc
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, remaining;
    logic [31:0]       word_buf;
    logic [1:0]        byte_idx;
    logic [7:0]        cur_byte, ser_data;
    logic              ser_valid, ser_ready, accept;
    assign cur_byte = word_buf[{byte_idx, 3'b000} +: 8];
    assign accept   = state == IDLE && start && !done;
    assign mem_addr = ptr;
    assign mem_read = state == RD_REQ;
    assign busy     = state != IDLE;
    assign ser_data = state == SUM ? xorc : cur_byte;
    always_comb begin
        state_n   = state;
        ser_valid = 1'b0;
        case (state)
            IDLE:    state_n = !accept ? IDLE : word_count == '0 ? SUM : RD_REQ;
            RD_REQ:  state_n = mem_ok ? SEND : RD_REQ;
            SEND: begin
                ser_valid = 1'b1;
                state_n   = ser_ready && byte_idx == 2'd3 ? NEXT : SEND;
            end
            NEXT:    state_n = remaining == ADDR_W'(1) ? SUM : RD_REQ;
            SUM: begin
                ser_valid = 1'b1;
                state_n   = ser_ready ? FIN : SUM;
            end
            FIN:     state_n = ser_ready ? IDLE : FIN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            word_buf  <= '0;
            byte_idx  <= '0;
            xorc      <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_n;
            done  <= state == FIN && ser_ready;
            if (accept) begin
                ptr       <= base_addr;
                remaining <= word_count;
                xorc      <= '0;
            end
            if (state == RD_REQ && mem_ok) begin
                word_buf <= mem_data;
                byte_idx <= '0;
            end
            if (state == SEND && ser_ready) begin
                xorc     <= xorc ^ cur_byte;
                byte_idx <= byte_idx + 2'd1;
            end
            if (state == NEXT) begin
                ptr       <= ptr + ADDR_W'(1);
                remaining <= remaining - ADDR_W'(1);
            end
        end
    end
    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (ser_data),
        .valid (ser_valid),
        .ready (ser_ready),
        .tx    (tx)
    );
endmodule

// File: tb/tb_rpg_dump.sv
// tb_rpg_dump: randomized and directed dumps checked cycle by cycle against an ideal UART stream model.
module tb_rpg_dump;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [22:0] base_addr = '0;
    logic [22:0] word_count = '0;
    logic [22:0] mem_addr;
    logic        mem_read;
    logic [31:0] mem_data = '0;
    logic        mem_ok = 1'b0;
    logic        tx, busy, done;
    logic [7:0]  xorc;

    rpg_dump #(.CLKS_PER_BIT(CPB), .ADDR_W(23)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_data(mem_data), .mem_ok(mem_ok),
        .tx(tx), .busy(busy), .done(done), .xorc(xorc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory model and responder
    logic [31:0] mem [logic [22:0]];
    logic [22:0] reads[$];
    int mem_dly = 1;
    int wcnt_mem = 0;
    always @(posedge clk) begin
        #1;
        if (mem_read && !rst) begin
            if (wcnt_mem >= mem_dly) begin
                mem_ok   = 1'b1;
                mem_data = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                reads.push_back(mem_addr);
                wcnt_mem = 0;
            end else begin
                mem_ok = 1'b0;
                wcnt_mem++;
            end
        end else begin
            mem_ok   = 1'b0;
            wcnt_mem = 0;
        end
    end

    // reference stream: expected bytes, checksum, and ideal back-to-back timing
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_xorc;
    bit          armed = 1'b0;
    bit          mon_on = 1'b0;
    int          t0 = -1;
    int          wcnt = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    logic        prev_rd = 1'b0, prev_ok = 1'b0;
    logic [22:0] prev_addr = '0;

    always @(negedge clk) begin
        int k, fr, b;
        logic [7:0] eb;
        logic       eb_bit;
        cyc++;
        if (armed && !rst) begin
            if (prev_rd && !prev_ok) begin
                chk("rd_hold", 32'(mem_read), 32'd1);
                chk("addr_hold", 32'(mem_addr), 32'(prev_addr));
            end
            if (mon_on) begin
                if (t0 < 0) begin
                    wcnt++;
                    if (wcnt >= 2) chk("busy_pre", 32'(busy), 32'd1);
                    if (tx === 1'b0) t0 = cyc;
                    else if (wcnt > 200) begin
                        total++;
                        bad++;
                        $display("FAIL first_start_bit: no start bit within 200 cycles");
                        mon_on = 1'b0;
                    end
                end
                if (t0 >= 0) begin
                    k = cyc - t0;
                    if (k < exp_q.size() * FRAME) begin
                        fr = k / FRAME;
                        b  = (k % FRAME) / CPB;
                        eb = exp_q[fr];
                        eb_bit = b == 0 ? 1'b0 : b == 9 ? 1'b1 : eb[b-1];
                        chk($sformatf("tx f%0d b%0d", fr, b), 32'(tx), 32'(eb_bit));
                        chk("done_early", 32'(done), 32'd0);
                        chk("busy_run", 32'(busy), 32'd1);
                    end else begin
                        chk("done_pulse", 32'(done), 32'd1);
                        chk("busy_end", 32'(busy), 32'd0);
                        chk("xorc_end", 32'(xorc), 32'(exp_xorc));
                        done_cyc = cyc;
                        done_cnt++;
                        mon_on = 1'b0;
                    end
                end
            end else begin
                chk("done_idle", 32'(done), 32'd0);
            end
        end
        prev_rd   = mem_read;
        prev_ok   = mem_ok;
        prev_addr = mem_addr;
    end

    task automatic dump(input logic [22:0] base, input int cnt, input int dly, input bit poke);
        logic [31:0] w;
        logic [7:0]  x;
        logic [22:0] a;
        int          lim;
        exp_q.delete();
        reads.delete();
        x = 8'h00;
        for (int i = 0; i < cnt; i++) begin
            a = 23'(base + 23'(i));
            w = mem.exists(a) ? mem[a] : 32'h0;
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back(w[j*8 +: 8]);
                x ^= w[j*8 +: 8];
            end
        end
        exp_q.push_back(x);
        exp_xorc = x;
        mem_dly  = dly;
        @(negedge clk);
        t0 = -1;
        wcnt = 0;
        done_cnt = 0;
        mon_on = 1'b1;
        start = 1'b1;
        base_addr = base;
        word_count = 23'(cnt);
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            for (int i = 0; i < 500 && !(t0 >= 0 && cyc >= t0 + FRAME + 10); i++) @(negedge clk);
            start = 1'b1;
            base_addr = 23'($urandom);
            word_count = 23'd5;
            @(negedge clk);
            start = 1'b0;
        end
        lim = (cnt * 4 + 1) * FRAME + cnt * (dly + 8) + 300;
        for (int i = 0; i < lim && mon_on; i++) @(negedge clk);
        if (mon_on) begin
            total++;
            bad++;
            $display("FAIL dump_timeout: done not seen within %0d cycles", lim);
            mon_on = 1'b0;
        end
        repeat (12) @(negedge clk);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("read_count", 32'(reads.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < reads.size(); i++)
            chk($sformatf("read_addr%0d", i), 32'(reads[i]), 32'(23'(base + 23'(i))));
    endtask

    initial begin
        logic [22:0] rb;
        int          rc;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_xorc", 32'(xorc), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        armed = 1'b1;

        mem[23'h000010] = 32'h12345678;
        dump(23'h000010, 1, 1, 1'b0);
        chk("single_xorc", 32'(xorc), 32'h08);
        chk("single_time", 32'(done_cyc - t0), 32'd200);
        chk("single_addr", 32'(reads.size() > 0 ? reads[0] : 23'h7fffff), 32'h10);

        dump(23'h000055, 0, 1, 1'b0);
        chk("empty_xorc", 32'(xorc), 32'h00);
        chk("empty_time", 32'(done_cyc - t0), 32'd40);

        mem[23'h000100] = 32'hCAFEF00D;
        mem[23'h000101] = 32'h0BADBEEF;
        dump(23'h000100, 2, 7, 1'b0);

        mem[23'h7FFFFF] = 32'hAABBCCDD;
        mem[23'h000000] = 32'h01020304;
        dump(23'h7FFFFF, 2, 1, 1'b0);
        chk("wrap_rd0", 32'(reads.size() > 0 ? reads[0] : 23'h0), 32'h7FFFFF);
        chk("wrap_rd1", 32'(reads.size() > 1 ? reads[1] : 23'h1), 32'h000000);
        chk("wrap_xorc", 32'(xorc), 32'h04);
        chk("wrap_time", 32'(done_cyc - t0), 32'd360);

        mem[23'h000200] = 32'h89ABCDEF;
        mem[23'h000201] = 32'h55AA0FF0;
        dump(23'h000200, 2, 2, 1'b1);

        for (int n = 0; n < 6; n++) begin
            rb = n == 0 ? 23'h7FFFFE : 23'($urandom);
            rc = $urandom_range(0, 3);
            for (int i = 0; i < rc; i++) mem[23'(rb + 23'(i))] = $urandom;
            dump(rb, rc, $urandom_range(1, 9), 1'b0);
        end

        // reset in the middle of the first frame
        armed = 1'b0;
        mem[23'h000300] = 32'h00000000;
        start = 1'b1;
        base_addr = 23'h000300;
        word_count = 23'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_tx", 32'(tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_mem_read", 32'(mem_read), 32'd0);
        chk("mid_rst_xorc", 32'(xorc), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        armed = 1'b1;
        mem[23'h000400] = 32'hDEADBEEF;
        dump(23'h000400, 1, 3, 1'b0);
        chk("post_rst_xorc", 32'(xorc), 32'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
